// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the HI/LO register pair.
// A start captures operands and runs a down-counter for MULT_CYC (multiply)
// or DIV_CYC (divide) cycles. The result is written to HI/LO on the final
// edge. Idle-cycle writes (MTHI/MTLO) copy operand a into HI or LO.
// Optional feature macro: MD_MADD_EN. When defined, op=00 with madd=1
// accumulates the signed product into {HI,LO}. When undefined, madd is
// ignored and no accumulator path exists.
module md_unit #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        madd,
    input  logic        wr,
    input  logic        wsel,
    input  logic        rsel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rdata
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_r;
    state_t      stateNext_s;
    logic        loadOp_s;
    logic        finish_s;
    logic        writeHi_s;
    logic        writeLo_s;

    logic [3:0]  cnt_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] aCap_r;
    logic [31:0] bCap_r;
    logic [1:0]  opCap_r;

    logic        signedOp_s;
    logic [63:0] aExt_s;
    logic [63:0] bExt_s;
    logic [63:0] prod_s;
    logic [63:0] mulRes_s;
    logic        aNeg_s;
    logic        bNeg_s;
    logic [31:0] aMag_s;
    logic [31:0] bMag_s;
    logic [31:0] qMag_s;
    logic [31:0] rMag_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [63:0] result_s;

`ifdef MD_MADD_EN
    logic        maddCap_r;
`else
    logic        unusedMadd_s;
    assign unusedMadd_s = madd;
`endif

    assign busy  = (state_r == ST_BUSY);
    assign stall = busy | start;
    assign rdata = rsel ? hi_r : lo_r;

    // Next-state and control decode: start wins over wr when idle, both ignored while busy.
    always_comb begin
        stateNext_s = state_r;
        loadOp_s    = 1'b0;
        finish_s    = 1'b0;
        writeHi_s   = 1'b0;
        writeLo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    stateNext_s = ST_BUSY;
                    loadOp_s    = 1'b1;
                end else if (wr) begin
                    stateNext_s = ST_IDLE;
                    writeHi_s   = wsel;
                    writeLo_s   = ~wsel;
                end else begin
                    stateNext_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd1) begin
                    stateNext_s = ST_IDLE;
                    finish_s    = 1'b1;
                end else begin
                    stateNext_s = ST_BUSY;
                end
            end
            default: begin
                stateNext_s = ST_IDLE;
            end
        endcase
    end

    // Result datapath: 64-bit product (optionally accumulated) and sign-magnitude divide.
    always_comb begin
        signedOp_s = ~opCap_r[0];
        aExt_s     = {{32{signedOp_s & aCap_r[31]}}, aCap_r};
        bExt_s     = {{32{signedOp_s & bCap_r[31]}}, bCap_r};
        prod_s     = aExt_s * bExt_s;
`ifdef MD_MADD_EN
        if (maddCap_r) begin
            mulRes_s = {hi_r, lo_r} + prod_s;
        end else begin
            mulRes_s = prod_s;
        end
`else
        mulRes_s   = prod_s;
`endif
        aNeg_s = signedOp_s & aCap_r[31];
        bNeg_s = signedOp_s & bCap_r[31];
        aMag_s = aNeg_s ? (32'd0 - aCap_r) : aCap_r;
        bMag_s = bNeg_s ? (32'd0 - bCap_r) : bCap_r;
        if (bCap_r == 32'd0) begin
            qMag_s = 32'd0;
            rMag_s = 32'd0;
            quot_s = 32'hFFFF_FFFF;
            rem_s  = aCap_r;
        end else begin
            // Magnitude divide makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
            qMag_s = aMag_s / bMag_s;
            rMag_s = aMag_s % bMag_s;
            quot_s = (aNeg_s ^ bNeg_s) ? (32'd0 - qMag_s) : qMag_s;
            rem_s  = aNeg_s ? (32'd0 - rMag_s) : rMag_s;
        end
        if (opCap_r[1]) begin
            result_s = {rem_s, quot_s};
        end else begin
            result_s = mulRes_s;
        end
    end

    // State, counter, operand capture and HI/LO update with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            aCap_r  <= 32'd0;
            bCap_r  <= 32'd0;
            opCap_r <= 2'b00;
        end else begin
            state_r <= stateNext_s;
            if (loadOp_s) begin
                aCap_r  <= a;
                bCap_r  <= b;
                opCap_r <= op;
                cnt_r   <= op[1] ? DIV_LOAD : MULT_LOAD;
            end else if (state_r == ST_BUSY) begin
                cnt_r   <= cnt_r - 4'd1;
            end else begin
                cnt_r   <= cnt_r;
            end
            if (finish_s) begin
                hi_r <= result_s[63:32];
                lo_r <= result_s[31:0];
            end else if (writeHi_s) begin
                hi_r <= a;
            end else if (writeLo_s) begin
                lo_r <= a;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

`ifdef MD_MADD_EN
    // Accumulate flag is only meaningful for signed multiply (op=00).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            maddCap_r <= 1'b0;
        end else if (loadOp_s) begin
            maddCap_r <= madd & (op == 2'b00);
        end else begin
            maddCap_r <= maddCap_r;
        end
    end
`endif

endmodule
